// File: rtl/dmux_pkg.sv
// Shared definitions for the 1:8 burst demux: channel count, select width
// and the scheduler state encoding.
package dmux_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/dmux_1by8_w.sv
// Combinational 1:8 demux of a W-bit beat. Only the addressed channel sees
// the data; every other channel is held at zero.
module dmux_1by8_w
  import dmux_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [W-1:0]        out_data,
  input  logic                out_valid,
  input  logic [SEL_W-1:0]    out_sel,
  output logic [NUM_CH*W-1:0] ch_data,
  output logic [NUM_CH-1:0]   ch_valid
);

  // Route the held beat to its channel, zero everywhere else.
  always_comb begin
    ch_valid = '0;
    ch_data  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (out_valid && (out_sel == SEL_W'(k))) begin
        ch_valid[k]       = 1'b1;
        ch_data[k*W +: W] = out_data;
      end
    end
  end

endmodule

// File: rtl/dmux_1by8_burst_sched.sv
// Burst scheduler for the 1:8 demux: picks a channel per burst (round-robin
// or directed), buffers one beat in an output register with valid/ready
// backpressure, and abandons a burst whose channel stalls too long.
module dmux_1by8_burst_sched
  import dmux_pkg::*;
#(
  parameter int W         = 1,
  parameter int BURST_LEN = 4,
  parameter int STALL_MAX = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mode,
  input  logic [SEL_W-1:0]    dir_sel,
  input  logic [NUM_CH-1:0]   ch_ready,
  output logic [NUM_CH-1:0]   ch_valid,
  output logic [NUM_CH*W-1:0] ch_data,
  output logic [SEL_W-1:0]    sel,
  output logic                busy,
  output logic                stall_err
);

  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam int SW = $clog2(STALL_MAX) + 1;

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic             burst_dir;
  logic [BW-1:0]    beat_cnt;
  logic [SW-1:0]    stall_cnt;

  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;
  logic             out_valid;

  logic             drain;
  logic             fire;
  logic             stalled;
  logic             abort;

  // The held beat drains to its own channel, independent of the current burst.
  assign drain    = out_valid && ch_ready[out_sel];
  assign in_ready = (state == XFER) && (!out_valid || ch_ready[out_sel]);
  assign fire     = in_valid && in_ready;
  assign stalled  = (state == XFER) && out_valid && !ch_ready[out_sel];
  assign abort    = stalled && (stall_cnt == SW'(STALL_MAX - 1));
  assign busy     = (state == XFER) || (state == GAP);

  // Scheduler FSM, burst/stall counters, round-robin pointer and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      burst_dir <= 1'b0;
      beat_cnt  <= '0;
      stall_cnt <= '0;
      sel       <= '0;
      stall_err <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
    end else begin
      stall_err <= 1'b0;

      if (fire) begin
        out_data  <= in_data;
        out_sel   <= sel;
        out_valid <= 1'b1;
      end else if (drain || abort) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            sel       <= mode ? dir_sel : rr_ptr;
            burst_dir <= mode;
            beat_cnt  <= '0;
            stall_cnt <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (abort) begin
            stall_err <= 1'b1;
            stall_cnt <= '0;
            state     <= GAP;
          end else begin
            if (drain) begin
              stall_cnt <= '0;
            end else if (stalled) begin
              stall_cnt <= stall_cnt + 1'b1;
            end
            if (fire) begin
              beat_cnt <= beat_cnt + 1'b1;
              if (beat_cnt == BW'(BURST_LEN - 1)) begin
                state <= GAP;
              end
            end
          end
        end
        GAP: begin
          if (!burst_dir) begin
            rr_ptr <= rr_ptr + 1'b1;
          end
          stall_cnt <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dmux_1by8_w #(.W(W)) u_demux (
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .ch_data   (ch_data),
    .ch_valid  (ch_valid)
  );

endmodule

// File: tb/tb_dmux_1by8_burst_sched.sv
// Directed bench for the 1:8 burst scheduler: reset, round-robin sweep with
// wrap, directed bursts, backpressure, stall abort and throughput timing.
module tb_dmux_1by8_burst_sched;

  localparam int W         = 8;
  localparam int BURST_LEN = 4;
  localparam int STALL_MAX = 16;

  logic          clk;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mode;
  logic [2:0]    dir_sel;
  logic [7:0]    ch_ready;
  logic [7:0]    ch_valid;
  logic [8*W-1:0] ch_data;
  logic [2:0]    sel;
  logic          busy;
  logic          stall_err;

  int total;
  int bad;
  int edge_no;
  int accept_q[$];
  int got_ch[$];
  int got_data[$];
  int exp_ch[$];
  int exp_data[$];

  dmux_1by8_burst_sched #(
    .W(W), .BURST_LEN(BURST_LEN), .STALL_MAX(STALL_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .dir_sel   (dir_sel),
    .ch_ready  (ch_ready),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .sel       (sel),
    .busy      (busy),
    .stall_err (stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    got_ch.delete();
    got_data.delete();
    exp_ch.delete();
    exp_data.delete();
    accept_q.delete();
    edge_no = 0;
  endtask

  // Present n consecutive beats; records the edge at which each is accepted.
  task automatic applyStimulus(input int n, input int first);
    int  waited;
    bit  fired;
    for (int i = 0; i < n; i++) begin
      in_data  = W'(first + i);
      in_valid = 1'b1;
      waited   = 0;
      fired    = 1'b0;
      while (!fired && waited < 60) begin
        @(negedge clk);
        fired = in_ready;
        @(posedge clk);
        #1;
        edge_no++;
        waited++;
      end
      if (!fired) begin
        checkOutput("send_timeout", 64'd0, 64'd1);
        return;
      end
      accept_q.push_back(edge_no);
    end
  endtask

  task automatic expectBeats(input int n, input int ch, input int first);
    for (int i = 0; i < n; i++) begin
      exp_ch.push_back(ch);
      exp_data.push_back(first + i);
    end
  endtask

  task automatic compareQueues(input string tag);
    int n;
    checkOutput({tag, "_count"}, 64'(got_ch.size()), 64'(exp_ch.size()));
    n = (got_ch.size() < exp_ch.size()) ? got_ch.size() : exp_ch.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_ch"}, 64'(got_ch[i]), 64'(exp_ch[i]));
      checkOutput({tag, "_data"}, 64'(got_data[i]), 64'(exp_data[i]));
    end
  endtask

  // Watch the channel side: every drained beat is logged, and idle channels must carry zero.
  always @(negedge clk) begin
    logic [8*W-1:0] mask;
    if (!rst) begin
      mask = '0;
      for (int k = 0; k < 8; k++) begin
        if (ch_valid[k]) mask[k*W +: W] = '1;
      end
      checkOutput("onehot", 64'($onehot0(ch_valid)), 64'd1);
      checkOutput("nonsel_zero", 64'(ch_data & ~mask), 64'd0);
      for (int k = 0; k < 8; k++) begin
        if (ch_valid[k] && ch_ready[k]) begin
          got_ch.push_back(k);
          got_data.push_back(int'(ch_data[k*W +: W]));
        end
      end
    end
  end

  initial begin
    int pulses;
    int pulse_at;
    total    = 0;
    bad      = 0;
    edge_no  = 0;
    rst      = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    mode     = 1'b0;
    dir_sel  = 3'd0;
    ch_ready = 8'hFF;

    // Reset values, then reset while a beat is held.
    doReset();
    checkOutput("rst_ch_valid", 64'(ch_valid), 64'd0);
    checkOutput("rst_sel", 64'(sel), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_stall_err", 64'(stall_err), 64'd0);
    in_valid = 1'b1;
    in_data  = 8'd7;
    tick();
    tick();
    checkOutput("t1_held_valid", 64'(ch_valid), 64'h01);
    rst = 1'b1;
    tick();
    checkOutput("t1_ch_valid", 64'(ch_valid), 64'd0);
    checkOutput("t1_sel", 64'(sel), 64'd0);
    checkOutput("t1_busy", 64'(busy), 64'd0);
    checkOutput("t1_in_ready", 64'(in_ready), 64'd0);
    doReset();

    // Round-robin sweep over all eight channels plus one wrapped burst.
    mode = 1'b0;
    applyStimulus(36, 0);
    in_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 36; i++) begin
      exp_ch.push_back((i / 4) % 8);
      exp_data.push_back(i);
    end
    compareQueues("t2_rr");
    checkOutput("t2_accepts", 64'(accept_q.size()), 64'd36);
    for (int i = 0; i < accept_q.size(); i++) begin
      checkOutput("t2_accept_edge", 64'(accept_q[i]), 64'(6 * (i / 4) + 2 + (i % 4)));
    end

    // Directed bursts: mid-burst dir_sel change is deferred; rr_ptr holds.
    doReset();
    mode = 1'b0;
    applyStimulus(4, 50);
    mode    = 1'b1;
    dir_sel = 3'd5;
    applyStimulus(6, 54);
    dir_sel = 3'd2;
    applyStimulus(2, 60);
    applyStimulus(4, 62);
    mode = 1'b0;
    applyStimulus(4, 66);
    in_valid = 1'b0;
    repeat (4) tick();
    expectBeats(4, 0, 50);
    expectBeats(8, 5, 54);
    expectBeats(4, 2, 62);
    expectBeats(4, 1, 66);
    compareQueues("t3_dir");

    // Backpressure on ch0 for three cycles mid-burst.
    doReset();
    in_valid = 1'b1;
    in_data  = 8'd100;
    tick();
    tick();
    checkOutput("t4_latency_valid", 64'(ch_valid), 64'h01);
    checkOutput("t4_latency_data", 64'(ch_data[7:0]), 64'd100);
    in_data = 8'd101;
    tick();
    in_data  = 8'd102;
    ch_ready = 8'hFE;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("t4_in_ready_low", 64'(in_ready), 64'd0);
      checkOutput("t4_hold_valid", 64'(ch_valid), 64'h01);
      checkOutput("t4_hold_data", 64'(ch_data[7:0]), 64'd101);
      tick();
    end
    ch_ready = 8'hFF;
    #1;
    checkOutput("t4_in_ready_back", 64'(in_ready), 64'd1);
    tick();
    in_data = 8'd103;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    expectBeats(4, 0, 100);
    compareQueues("t4_bp");

    // Stall abort after STALL_MAX stalled cycles; next burst moves to ch1.
    doReset();
    in_valid = 1'b1;
    in_data  = 8'd200;
    ch_ready = 8'h00;
    tick();
    tick();
    in_valid = 1'b0;
    checkOutput("t5_held", 64'(ch_valid), 64'h01);
    pulses   = 0;
    pulse_at = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (stall_err) begin
        pulses++;
        pulse_at = k;
      end
    end
    checkOutput("t5_pulses", 64'(pulses), 64'd1);
    checkOutput("t5_pulse_at", 64'(pulse_at), 64'(STALL_MAX));
    checkOutput("t5_dropped", 64'(ch_valid), 64'd0);
    checkOutput("t5_busy", 64'(busy), 64'd0);
    ch_ready = 8'hFF;
    applyStimulus(4, 210);
    in_valid = 1'b0;
    repeat (4) tick();
    expectBeats(4, 1, 210);
    compareQueues("t5_next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
